udp_tx_framer: RTL

Parametrised store-and-forward UDP/IPv4/Ethernet transmit framer for MII/RMII PHYs. It is the successor to the fixed-length packet generator and adds these features:
- Frame length is taken from TLAST, not a sideband.
- IPv4 header checksum is computed at run time; the IP identification field increments per frame.
- Payloads are padded to the 64-byte minimum frame.
- FCS is computed internally; nibble width is selectable.
- Oversize payloads are truncated and counted.

It sits between the AXI-Stream payload source and the PHY TX pins.

---
 rtl/udp_tx_framer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/udp_tx_framer.sv
// udp_tx_framer: store-and-forward UDP/IPv4/Ethernet transmit framer for MII/RMII PHYs.
// Payload is buffered until TLAST, then sent with preamble, headers, padding and FCS.
module udp_tx_framer #(
   parameter int          MII_WIDTH      = 2,
   parameter int          FIFO_DEPTH     = 2048,
   parameter int          LEN_FIFO_DEPTH = 8,
   parameter int          MAX_PAYLOAD    = 1472,
   parameter int          IFG_BYTES      = 12,
   parameter logic [47:0] FPGA_MAC       = 48'he86a64e7e830,
   parameter logic [47:0] HOST_MAC       = 48'he86a64e7e829,
   parameter logic [31:0] FPGA_IP        = 32'hC0A80164,
   parameter logic [31:0] HOST_IP        = 32'hC0A80165,
   parameter logic [15:0] FPGA_PORT      = 16'h4567,
   parameter logic [15:0] HOST_PORT      = 16'h4567
) (
   input  logic                 CLK,
   input  logic                 reset_n,
   input  logic [7:0]           S_AXIS_TDATA,
   input  logic                 S_AXIS_TVALID,
   input  logic                 S_AXIS_TLAST,
   output logic                 S_AXIS_TREADY,
   output logic                 TX_EN,
   output logic [MII_WIDTH-1:0] TXD,
   output logic [15:0]          frame_count,
   output logic [7:0]           truncate_count
);
   localparam int          AW   = $clog2(FIFO_DEPTH);
   localparam int          LW   = $clog2(LEN_FIFO_DEPTH);
   localparam logic [2:0]  CM1  = 3'(8 / MII_WIDTH - 1);
   localparam logic [15:0] MAXP = 16'(MAX_PAYLOAD);
   localparam logic [15:0] IFGB = 16'(IFG_BYTES);

   typedef enum logic [3:0] {IDLE, CALC, PREAMBLE, SFD, HEADER, DATA, PAD, FCS, IFG} state_t;

   logic [7:0]           pmem [FIFO_DEPTH];
   logic [15:0]          lmem [LEN_FIFO_DEPTH];
   logic [AW:0]          pwr, prd;
   logic [LW:0]          lwr, lrd;
   logic [15:0]          beats, plen, ip_id, bcnt, blen, tot_len, udp_len, csum, fold;
   logic [16:0]          f1;
   logic [31:0]          csum_acc, crc, crc_nxt;
   logic [335:0]         hdr;
   logic [8:0]           hidx;
   logic [2:0]           ccnt, sh;
   logic [7:0]           cur;
   logic                 trunc, run, pfull, lfull, lempty, acc, wr_byte, last_b;
   logic                 calc1, last_chunk, st_done, pop_len, pop_byte, crc_en, tx_en_d;
   logic [MII_WIDTH-1:0] txd_d;
   state_t               state, nxt;

   // ingress: bytes past MAX_PAYLOAD are still accepted but never stored
   assign pfull         = (pwr ^ prd) == {1'b1, {AW{1'b0}}};
   assign lfull         = (lwr ^ lrd) == {1'b1, {LW{1'b0}}};
   assign lempty        = lwr == lrd;
   assign S_AXIS_TREADY = run && !pfull && !lfull;
   assign acc           = S_AXIS_TVALID && S_AXIS_TREADY;
   assign wr_byte       = acc && beats < MAXP;
   assign last_b        = acc && S_AXIS_TLAST;

   always_ff @(posedge CLK) begin
      if (wr_byte) pmem[pwr[AW-1:0]] <= S_AXIS_TDATA;
      if (last_b) lmem[lwr[LW-1:0]] <= wr_byte ? beats + 16'd1 : beats;
   end

   always_ff @(posedge CLK or negedge reset_n)
      if (!reset_n) begin
         run            <= 1'b0;
         pwr            <= '0;
         lwr            <= '0;
         beats          <= '0;
         trunc          <= 1'b0;
         truncate_count <= '0;
      end else begin
         run <= 1'b1;
         if (wr_byte) begin
            pwr   <= pwr + 1'b1;
            beats <= beats + 16'd1;
         end
         if (last_b) begin
            lwr   <= lwr + 1'b1;
            beats <= '0;
            trunc <= 1'b0;
            if ((trunc || !wr_byte) && truncate_count != 8'hFF) truncate_count <= truncate_count + 8'd1;
         end else if (acc && !wr_byte) trunc <= 1'b1;
      end

   assign tot_len    = plen + 16'd28;
   assign udp_len    = plen + 16'd8;
   assign hdr        = {HOST_MAC, FPGA_MAC, 16'h0800, 16'h4500, tot_len, ip_id, 16'h4000, 16'h4011,
                        csum, FPGA_IP, HOST_IP, FPGA_PORT, HOST_PORT, udp_len, 16'h0000};
   assign hidx       = 9'd328 - {bcnt[5:0], 3'b000};
   assign f1         = {1'b0, csum_acc[15:0]} + {1'b0, csum_acc[31:16]};
   assign fold       = f1[15:0] + {15'd0, f1[16]};
   assign last_chunk = ccnt == CM1;
   assign blen       = state == PREAMBLE ? 16'd7 : state == HEADER ? 16'd42 : state == DATA ? plen :
                       state == PAD ? 16'd18 - plen : state == FCS ? 16'd4 : state == IFG ? IFGB : 16'd1;
   assign st_done    = last_chunk && bcnt == blen - 16'd1;

   always_ff @(posedge CLK or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else state <= nxt;

   always_comb begin
      nxt = state;
      case (state)
         IDLE:     if (!lempty) nxt = CALC;
         CALC:     if (calc1) nxt = PREAMBLE;
         PREAMBLE: if (st_done) nxt = SFD;
         SFD:      if (st_done) nxt = HEADER;
         HEADER:   if (st_done) nxt = DATA;
         DATA:     if (st_done) nxt = plen < 16'd18 ? PAD : FCS;
         PAD:      if (st_done) nxt = FCS;
         FCS:      if (st_done) nxt = IFG;
         IFG:      if (st_done) nxt = IDLE;
         default:  nxt = IDLE;
      endcase
   end

   always_comb begin
      pop_len  = state == IDLE && !lempty;
      pop_byte = state == DATA && last_chunk;
      crc_en   = state == HEADER || state == DATA || state == PAD;
      tx_en_d  = state inside {PREAMBLE, SFD, HEADER, DATA, PAD, FCS};
      cur      = state == PREAMBLE ? 8'h55 : state == SFD ? 8'hD5 : state == HEADER ? hdr[hidx +: 8] :
                 state == DATA ? pmem[prd[AW-1:0]] : state == FCS ? ~crc[{bcnt[1:0], 3'b000} +: 8] : 8'h00;
      sh       = 3'(ccnt * MII_WIDTH);
      txd_d    = cur[sh +: MII_WIDTH];
   end

   // reflected CRC-32 advanced by exactly the bits leaving this cycle
   always_comb begin
      crc_nxt = crc;
      for (int i = 0; i < MII_WIDTH; i++)
         crc_nxt = (crc_nxt >> 1) ^ ((crc_nxt[0] ^ txd_d[i]) ? 32'hEDB88320 : 32'h0);
   end

   always_ff @(posedge CLK or negedge reset_n)
      if (!reset_n) begin
         ccnt        <= '0;
         bcnt        <= '0;
         calc1       <= 1'b0;
         csum_acc    <= '0;
         csum        <= '0;
         plen        <= '0;
         ip_id       <= '0;
         frame_count <= '0;
         crc         <= '1;
         prd         <= '0;
         lrd         <= '0;
         TX_EN       <= 1'b0;
         TXD         <= '0;
      end else begin
         ccnt  <= (state == IDLE || state == CALC || last_chunk) ? 3'd0 : ccnt + 3'd1;
         bcnt  <= nxt != state ? 16'd0 : last_chunk ? bcnt + 16'd1 : bcnt;
         calc1 <= state == CALC && !calc1;
         if (state == CALC && !calc1)
            csum_acc <= 32'h4500 + tot_len + ip_id + 32'h4000 + 32'h4011 + FPGA_IP[31:16] +
                        FPGA_IP[15:0] + HOST_IP[31:16] + HOST_IP[15:0];
         if (calc1) csum <= ~fold;
         if (pop_len) begin
            plen <= lmem[lrd[LW-1:0]];
            lrd  <= lrd + 1'b1;
         end
         if (pop_byte) prd <= prd + 1'b1;
         crc <= state == CALC ? '1 : crc_en ? crc_nxt : crc;
         if (state == IFG && st_done) begin
            frame_count <= frame_count + 16'd1;
            ip_id       <= ip_id + 16'd1;
         end
         TX_EN <= tx_en_d;
         TXD   <= txd_d;
      end
endmodule
